// File: rtl/mux4_arb_pkg.sv
// rtl/mux4_arb_pkg.sv - shared constants, state enum and rotation helpers for the 4:1 mux arbiter
package mux4_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // First requester after `last` in rotation order; `last` itself is checked last.
  // Scanning far-to-near lets the nearest pending channel overwrite the result.
  function automatic logic [SEL_W-1:0] next_req(
    input logic [NUM_CH-1:0] req,
    input logic [SEL_W-1:0]  last
  );
    logic [SEL_W-1:0] idx;
    next_req = last;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) next_req = idx;
    end
  endfunction

  function automatic logic [NUM_CH-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    to_onehot = NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_sel.sv
// rtl/mux4_sel.sv - combinational DATA_W-wide 4:1 selector
module mux4_sel
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]        y_raw
);

  always_comb begin
    y_raw = '0;
    case (sel)
      2'd0: y_raw = data_in[0*DATA_W +: DATA_W];
      2'd1: y_raw = data_in[1*DATA_W +: DATA_W];
      2'd2: y_raw = data_in[2*DATA_W +: DATA_W];
      2'd3: y_raw = data_in[3*DATA_W +: DATA_W];
      default: y_raw = '0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin hold-limited arbiter driving a shared 4:1 mux; MUX_ARB_LOCK_EN adds a lock input
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef MUX_ARB_LOCK_EN
  input  logic                     lock,
`endif
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic [NUM_CH-1:0]        gnt,
  output logic [SEL_W-1:0]         sel,
  output logic                     valid,
  output logic [DATA_W-1:0]        y
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

  arb_state_t        state, state_nxt;
  logic [SEL_W-1:0]  last, last_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [3:0]        hold_cnt, hold_nxt;
  logic [NUM_CH-1:0] gnt_nxt;
  logic              valid_nxt;
  logic [NUM_CH-1:0] others;
  logic              holder_req;
  logic              lock_active;
  logic              take;
  logic [SEL_W-1:0]  pick;
  logic [DATA_W-1:0] y_raw;

`ifdef MUX_ARB_LOCK_EN
  assign lock_active = lock;
`else
  assign lock_active = 1'b0;
`endif

  // Holder is excluded so a release and new requests resolve on one edge.
  assign others     = req & ~to_onehot(last);
  assign holder_req = req[last];

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    valid_nxt = valid;
    hold_nxt  = hold_cnt;
    take      = 1'b0;
    pick      = last;

    case (state)
      IDLE: begin
        if (|req) begin
          take = 1'b1;
          pick = next_req(req, last);
        end
      end
      GRANT: begin
        if (!holder_req) begin
          if (|others) begin
            take = 1'b1;
            pick = next_req(others, last);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
          end
        end else if (hold_cnt == HOLD_LIM && |others && !lock_active) begin
          take = 1'b1;
          pick = next_req(others, last);
        end else if (hold_cnt != HOLD_LIM) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        hold_nxt  = '0;
      end
    endcase

    if (take) begin
      state_nxt = GRANT;
      last_nxt  = pick;
      sel_nxt   = pick;
      gnt_nxt   = to_onehot(pick);
      valid_nxt = 1'b1;
      hold_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 2'd3;
      sel      <= 2'd0;
      gnt      <= '0;
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      sel      <= sel_nxt;
      gnt      <= gnt_nxt;
      valid    <= valid_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  mux4_sel #(
    .DATA_W (DATA_W)
  ) u_sel (
    .sel     (sel),
    .data_in (data_in),
    .y_raw   (y_raw)
  );

  assign y = valid ? y_raw : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter; lock scenario built with MUX_ARB_LOCK_EN
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] data_in = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       y;
`ifdef MUX_ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t sb[$];

  mux4_rr_arbiter #(
    .DATA_W   (1),
    .HOLD_MAX (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef MUX_ARB_LOCK_EN
    .lock    (lock),
`endif
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .y       (y)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic v);
    exp_t e;
    e.req = r; e.gnt = g; e.sel = s; e.valid = v;
    sb.push_back(e);
  endtask

  task automatic tick(input logic [3:0] r);
    req     = r;
    data_in = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({gnt, sel, valid, y} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b sel=%0d valid=%b y=%b, want all zero", gnt, sel, valid, y);
    end
    rst_n = 1'b1;
    push(4'b0100, 4'b0100, 2'd2, 1'b1);
    push(4'b0000, 4'b0000, 2'd2, 1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL reset_first_grant: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
  endtask

  task automatic test_all_four;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) push(4'hF, 4'b0001 << c, 2'(c), 1'b1);
    end
    push(4'hF, 4'b0001, 2'd0, 1'b1);
    push(4'h0, 4'b0000, 2'd0, 1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL all_four_rotation: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
  endtask

  task automatic test_early_release;
    push(4'b0010, 4'b0010, 2'd1, 1'b1);
    push(4'b1010, 4'b0010, 2'd1, 1'b1);
    push(4'b1010, 4'b0010, 2'd1, 1'b1);
    push(4'b1000, 4'b1000, 2'd3, 1'b1);
    push(4'b0000, 4'b0000, 2'd3, 1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL early_release: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
  endtask

  task automatic test_lone_requester;
    for (int k = 0; k < 20; k++) push(4'b0001, 4'b0001, 2'd0, 1'b1);
    push(4'b0000, 4'b0000, 2'd0, 1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL lone_requester: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
      // y follows data_in between edges without waiting for a clock
      if (sb.size() == 10) begin
        data_in = 4'b1110;
        #1;
        n_tests++;
        if (y !== 1'b0) begin
          n_fail++;
          $display("FAIL y_tracking_low: got y=%b, want y=0", y);
        end
        data_in = 4'b0001;
        #1;
        n_tests++;
        if (y !== 1'b1) begin
          n_fail++;
          $display("FAIL y_tracking_high: got y=%b, want y=1", y);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    push(4'b0100, 4'b0100, 2'd2, 1'b1);
    push(4'b1011, 4'b1000, 2'd3, 1'b1);
    push(4'b0011, 4'b0001, 2'd0, 1'b1);
    push(4'b0000, 4'b0000, 2'd0, 1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL back_to_back: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
  endtask

  task automatic test_async_reset;
    push(4'b0100, 4'b0100, 2'd2, 1'b1);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL async_pre_grant: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
    data_in = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, sel, valid, y} !== 8'b0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got gnt=%b sel=%0d valid=%b y=%b, want all zero", gnt, sel, valid, y);
    end
    req = 4'b1111;
    #1;
    rst_n = 1'b1;
    push(4'b1111, 4'b0001, 2'd0, 1'b1);
    push(4'b0000, 4'b0000, 2'd0, 1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL async_restart: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lock  = 1'b1;
    for (int k = 0; k < 10; k++) push(4'b0011, 4'b0001, 2'd0, 1'b1);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL lock_hold: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
    lock = 1'b0;
    push(4'b0011, 4'b0010, 2'd1, 1'b1);
    push(4'b0000, 4'b0000, 2'd1, 1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      logic ey;
      e = sb.pop_front();
      tick(e.req);
      ey = e.valid ? data_in[e.sel] : 1'b0;
      n_tests++;
      if ({gnt, sel, valid, y} !== {e.gnt, e.sel, e.valid, ey}) begin
        n_fail++;
        $display("FAIL lock_release: got gnt=%b sel=%0d valid=%b y=%b, want gnt=%b sel=%0d valid=%b y=%b",
                 gnt, sel, valid, y, e.gnt, e.sel, e.valid, ey);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_four();
    test_early_release();
    test_lone_requester();
    test_back_to_back();
    test_async_reset();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin scheduler that shares a 4:1 data multiplexer between four requesters. It sequences the mux select lines so that exactly one requester owns the shared output at a time. It bounds each ownership period with a hold limit and rotates fairly among pending requests. It sits in front of the gate-level 4:1 mux datapath and replaces free-running select stimulus with request-driven control.

## Interface
- DATA_W, 1, width of each channel's data and of the shared output.
- HOLD_MAX, 4, maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel request, level-sensitive; bit i = channel Ci.
- data_in  input  4*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  registered mux select, {A,B} encoding; index of the granted channel.
- valid  output  1  registered; high while any grant is active.
- y  output  DATA_W  shared output: selected channel's data_in when valid, else 0; combinational from registered sel.
- lock  input  1  present only with MUX_ARB_LOCK_EN; see Configuration.

## Operation
- State machine in package enum: IDLE, GRANT.
- Rotation pointer `last` (2 bits) holds the index of the most recently granted channel. Search order is last+1, last+2, last+3, last (mod 4, wrap 3->0).
- IDLE: if req != 0, grant the first requester in search order. Go to GRANT, load `last`, and clear hold_cnt. Otherwise stay in IDLE with gnt=0.
- GRANT, holder's req low: re-arbitrate on the same edge among the other requests.
  - If any are pending, switch directly to the winner; no idle bubble.
  - Otherwise go to IDLE.
- GRANT, holder's req high, hold_cnt == HOLD_MAX-1, and another req pending: rotate to the next pending requester in search order. Clear hold_cnt.
- GRANT, holder's req high, no other req: keep the grant. hold_cnt saturates at HOLD_MAX-1.
- Otherwise keep the grant and increment hold_cnt.
- hold_cnt is 4 bits. It increments once per cycle in GRANT and never wraps.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit. When idle, sel holds its last value.

## Timing
- Reset values: gnt=0, sel=2'b00, valid=0, y=0, state=IDLE, last=2'd3 (first search starts at channel 0), hold_cnt=0.
- Reset asserts asynchronously mid-grant: all outputs clear immediately. The first arbitration occurs on the first rising edge after rst_n deasserts.
- Grant latency: req sampled high at edge N gives gnt/sel/valid high after edge N (1 cycle).
- Release latency: holder drops req before edge N; the new grant or idle takes effect after edge N.
- y tracks data_in combinationally with zero cycles from data_in change. It uses sel registered at the previous edge.
- Simultaneous release by the holder and new requests is handled in one edge. The new requests are arbitrated with the holder excluded.
- HOLD_MAX=1: the grant rotates every cycle while two or more channels request.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - Adds the `lock` input.
  - While the holder's req and lock are both high, the hold-limit rotation is suppressed and the holder keeps the grant indefinitely.
  - hold_cnt still saturates.
  - Dropping lock re-enables rotation on the next edge if hold_cnt is saturated.
- Not defined: no `lock` port, and the hold limit always applies.

## Structure
- Package mux4_arb_pkg:
  - NUM_CH=4 and SEL_W=2.
  - The state enum {IDLE, GRANT}.
  - A function returning the next requester index given req and last.
- Sub-module mux4_sel: purely combinational DATA_W-wide 4:1 selector (sel, data_in -> raw output). The top gates it with valid to form y.

## Test plan
- Reset then single request: rst_n low with req=4'b0100, then release → outputs stay 0 during reset. After the first edge: gnt=4'b0100, sel=2, valid=1, y=data_in ch2.
- All four request continuously, HOLD_MAX=4, from reset → grant order 0,1,2,3,0. Each grant lasts exactly 4 cycles, with no zero-gnt cycle between grants.
- Holder releases early: ch1 granted, ch3 pending; ch1 drops req after 2 cycles → gnt=4'b1000 on the next edge with no bubble. With nothing pending → gnt=0, valid=0, y=0.
- Lone requester: only ch0 requests for 20 cycles → gnt stays 4'b0001 throughout. hold_cnt saturates at 3 with no glitch.
- Async reset mid-grant: rst_n pulsed low between edges while ch2 holds → gnt, valid and y go 0 immediately. After release, with all requesting, the grant restarts at ch0.
- With MUX_ARB_LOCK_EN: ch0 locked and ch1 requesting for 10 cycles → ch0 keeps the grant. Lock dropped → gnt=4'b0010 on the next edge.
